// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: decides which symbol hits from the match pipeline are written to the mark FIFO
module trace_capture_ctrl #(
    parameter int SYMBOL_W = 5,
    parameter int LEVEL_W  = 9,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_cfg_wr,
    input  logic [2:0]          i_cfg_addr,
    input  logic [31:0]         i_cfg_wdata,
    input  logic                i_hit_valid,
    input  logic [SYMBOL_W-1:0] i_hit_symbol,
    input  logic [31:0]         i_hit_perf,
    input  logic [LEVEL_W-1:0]  i_fifo_level,
    output logic                o_mark_wr,
    output logic [SYMBOL_W-1:0] o_mark_symbol,
    output logic [31:0]         o_mark_perf,
    output logic [2:0]          o_state,
    output logic [COUNT_W-1:0]  o_mark_count,
    output logic [COUNT_W-1:0]  o_drop_count,
    output logic                o_done,
    output logic                o_irq,
    output logic                o_cfg_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                start_en_q, start_en_d;
    logic                stop_en_q, stop_en_d;
    logic [SYMBOL_W-1:0] start_sym_q, start_sym_d;
    logic [SYMBOL_W-1:0] stop_sym_q, stop_sym_d;
    logic [COUNT_W-1:0]  max_marks_q, max_marks_d;
    logic [LEVEL_W-1:0]  high_water_q, high_water_d;
    logic                mark_wr_q, mark_wr_d;
    logic [SYMBOL_W-1:0] mark_symbol_q, mark_symbol_d;
    logic [31:0]         mark_perf_q, mark_perf_d;
    logic [COUNT_W-1:0]  mark_count_q, mark_count_d;
    logic [COUNT_W-1:0]  drop_count_q, drop_count_d;
    logic                irq_q, irq_d;
    logic                cfg_err_q, cfg_err_d;

    logic               quiet, arm, abort, fwd, drp, stop_hit, budget_hit, above_hw;
    logic [COUNT_W-1:0] cnt_inc;

    assign quiet      = (state_q == IDLE) || (state_q == DONE);
    assign arm        = i_cfg_wr && (i_cfg_addr == 3'd0) && i_cfg_wdata[0];
    assign abort      = i_cfg_wr && (i_cfg_addr == 3'd0) && i_cfg_wdata[1];
    assign cnt_inc    = mark_count_q + 1'b1;
    assign stop_hit   = stop_en_q && (i_hit_symbol == stop_sym_q);
    assign budget_hit = (max_marks_q != '0) && (cnt_inc == max_marks_q);
    assign above_hw   = i_fifo_level >= high_water_q;

    // Config decode, FSM next state, forward/drop decisions and counter updates
    always_comb begin
        state_d       = state_q;
        start_en_d    = start_en_q;
        stop_en_d     = stop_en_q;
        start_sym_d   = start_sym_q;
        stop_sym_d    = stop_sym_q;
        max_marks_d   = max_marks_q;
        high_water_d  = high_water_q;
        mark_wr_d     = 1'b0;
        mark_symbol_d = mark_symbol_q;
        mark_perf_d   = mark_perf_q;
        mark_count_d  = mark_count_q;
        drop_count_d  = drop_count_q;
        irq_d         = 1'b0;
        cfg_err_d     = 1'b0;
        fwd           = 1'b0;
        drp           = 1'b0;
        if (i_cfg_wr && quiet) begin
            case (i_cfg_addr)
                3'd0: begin
                    start_en_d = i_cfg_wdata[2];
                    stop_en_d  = i_cfg_wdata[3];
                end
                3'd1: start_sym_d  = i_cfg_wdata[SYMBOL_W-1:0];
                3'd2: stop_sym_d   = i_cfg_wdata[SYMBOL_W-1:0];
                3'd3: max_marks_d  = i_cfg_wdata[COUNT_W-1:0];
                3'd4: high_water_d = i_cfg_wdata[LEVEL_W-1:0];
                default: ;
            endcase
        end else if (i_cfg_wr) begin
            // A busy-state CTRL write only errors if it tries to change the trigger enables
            cfg_err_d = ((i_cfg_addr >= 3'd1) && (i_cfg_addr <= 3'd4)) ||
                        ((i_cfg_addr == 3'd0) && (i_cfg_wdata[3:2] != {stop_en_q, start_en_q}));
        end
        if (abort) begin
            state_d = IDLE;
        end else if (arm) begin
            state_d      = ARMED;
            mark_count_d = '0;
            drop_count_d = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    state_d = start_en_q ? ARMED : CAPTURE;
                    fwd     = start_en_q && i_hit_valid && (i_hit_symbol == start_sym_q);
                end
                CAPTURE: begin
                    state_d = above_hw ? PAUSED : CAPTURE;
                    fwd     = i_hit_valid && !above_hw;
                    drp     = i_hit_valid && above_hw;
                end
                PAUSED: begin
                    state_d = above_hw ? PAUSED : CAPTURE;
                    drp     = i_hit_valid;
                end
                default: ;
            endcase
        end
        if (fwd) begin
            mark_wr_d     = 1'b1;
            mark_symbol_d = i_hit_symbol;
            mark_perf_d   = i_hit_perf;
            mark_count_d  = cnt_inc;
            irq_d         = stop_hit || budget_hit;
            state_d       = (stop_hit || budget_hit) ? DONE : CAPTURE;
        end
        if (drp) begin
            drop_count_d = (&drop_count_q) ? drop_count_q : drop_count_q + 1'b1;
        end
    end

    // State, configuration and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            start_en_q    <= 1'b0;
            stop_en_q     <= 1'b0;
            start_sym_q   <= '0;
            stop_sym_q    <= '0;
            max_marks_q   <= '0;
            high_water_q  <= LEVEL_W'(240);
            mark_wr_q     <= 1'b0;
            mark_symbol_q <= '0;
            mark_perf_q   <= '0;
            mark_count_q  <= '0;
            drop_count_q  <= '0;
            irq_q         <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_en_q    <= start_en_d;
            stop_en_q     <= stop_en_d;
            start_sym_q   <= start_sym_d;
            stop_sym_q    <= stop_sym_d;
            max_marks_q   <= max_marks_d;
            high_water_q  <= high_water_d;
            mark_wr_q     <= mark_wr_d;
            mark_symbol_q <= mark_symbol_d;
            mark_perf_q   <= mark_perf_d;
            mark_count_q  <= mark_count_d;
            drop_count_q  <= drop_count_d;
            irq_q         <= irq_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign o_mark_wr     = mark_wr_q;
    assign o_mark_symbol = mark_symbol_q;
    assign o_mark_perf   = mark_perf_q;
    assign o_state       = state_q;
    assign o_mark_count  = mark_count_q;
    assign o_drop_count  = drop_count_q;
    assign o_done        = state_q == DONE;
    assign o_irq         = irq_q;
    assign o_cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb_trace_capture_ctrl: directed scoreboard bench for trace_capture_ctrl
module tb_trace_capture_ctrl;

    typedef struct packed {
        logic [4:0]  sym;
        logic [31:0] perf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_cfg_wr;
    logic [2:0]  i_cfg_addr;
    logic [31:0] i_cfg_wdata;
    logic        i_hit_valid;
    logic [4:0]  i_hit_symbol;
    logic [31:0] i_hit_perf;
    logic [8:0]  i_fifo_level;
    logic        o_mark_wr;
    logic [4:0]  o_mark_symbol;
    logic [31:0] o_mark_perf;
    logic [2:0]  o_state;
    logic [15:0] o_mark_count;
    logic [15:0] o_drop_count;
    logic        o_done;
    logic        o_irq;
    logic        o_cfg_err;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   errors  = 0;
    int   irq_cnt = 0;
    int   s2 [5] = '{2, 7, 4, 9, 5};
    bit   e2 [5] = '{0, 1, 1, 1, 0};

    trace_capture_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_wr(i_cfg_wr), .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata),
        .i_hit_valid(i_hit_valid), .i_hit_symbol(i_hit_symbol), .i_hit_perf(i_hit_perf),
        .i_fifo_level(i_fifo_level),
        .o_mark_wr(o_mark_wr), .o_mark_symbol(o_mark_symbol), .o_mark_perf(o_mark_perf),
        .o_state(o_state), .o_mark_count(o_mark_count), .o_drop_count(o_drop_count),
        .o_done(o_done), .o_irq(o_irq), .o_cfg_err(o_cfg_err)
    );

    always #5 clk = ~clk;

    // Monitor: every write the DUT presents must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_irq) irq_cnt++;
            if (o_mark_wr) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got sym=%0d perf=%h required no write", o_mark_symbol, o_mark_perf);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (o_mark_symbol !== mon_e.sym || o_mark_perf !== mon_e.perf) begin
                        errors++;
                        $display("FAIL mark_write got sym=%0d perf=%h required sym=%0d perf=%h",
                                 o_mark_symbol, o_mark_perf, mon_e.sym, mon_e.perf);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] a, input logic [31:0] d);
        i_cfg_wr = 1'b1; i_cfg_addr = a; i_cfg_wdata = d;
        cyc();
        i_cfg_wr = 1'b0;
    endtask

    task automatic hit(input logic [4:0] s, input logic [31:0] p, input bit fwd);
        if (fwd) exp_q.push_back({s, p});
        i_hit_valid = 1'b1; i_hit_symbol = s; i_hit_perf = p;
        cyc();
        i_hit_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; i_cfg_wr = 1'b0; i_cfg_addr = '0; i_cfg_wdata = '0;
        i_hit_valid = 1'b0; i_hit_symbol = '0; i_hit_perf = '0; i_fifo_level = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_state", 32'(o_state), 0);
        check("reset_mark_wr", 32'(o_mark_wr), 0);
        check("reset_done", 32'(o_done), 0);
        check("reset_mark_count", 32'(o_mark_count), 0);

        // 1: free-running capture, one-cycle forward latency
        cfg(3'd0, 32'h1);
        check("t1_armed", 32'(o_state), 1);
        cyc();
        check("t1_capture", 32'(o_state), 2);
        for (int i = 0; i < 5; i++) begin
            hit(5'd3, 32'h100 + 32'(i), 1'b1);
            check("t1_latency", 32'(o_mark_wr), 1);
        end
        cyc();
        check("t1_mark_count", 32'(o_mark_count), 5);
        check("t1_state", 32'(o_state), 2);

        // 2: start/stop triggers
        cfg(3'd0, 32'h2);
        check("t2_abort_idle", 32'(o_state), 0);
        check("t2_count_hold", 32'(o_mark_count), 5);
        cfg(3'd1, 32'd7);
        cfg(3'd2, 32'd9);
        cfg(3'd0, 32'hD);
        check("t2_arm_clear", 32'(o_mark_count), 0);
        for (int i = 0; i < 5; i++) hit(5'(s2[i]), 32'h200 + 32'(i), e2[i]);
        cyc();
        check("t2_state_done", 32'(o_state), 4);
        check("t2_done", 32'(o_done), 1);
        check("t2_mark_count", 32'(o_mark_count), 3);
        check("t2_irq_count", 32'(irq_cnt), 1);

        // 3: mark budget with back-to-back hits
        cfg(3'd0, 32'h0);
        cfg(3'd3, 32'd3);
        cfg(3'd0, 32'h1);
        cyc();
        for (int i = 0; i < 6; i++) hit(5'd11, 32'h300 + 32'(i), i < 3);
        cyc();
        check("t3_done", 32'(o_done), 1);
        check("t3_mark_count", 32'(o_mark_count), 3);
        check("t3_irq_count", 32'(irq_cnt), 2);

        // 4: high-water pause and resume
        cfg(3'd3, 32'd0);
        cfg(3'd4, 32'd4);
        cfg(3'd0, 32'h1);
        cyc();
        i_fifo_level = 9'd4;
        for (int i = 0; i < 6; i++) hit(5'd6, 32'h400 + 32'(i), 1'b0);
        check("t4_paused", 32'(o_state), 3);
        check("t4_drop_count", 32'(o_drop_count), 6);
        check("t4_mark_count", 32'(o_mark_count), 0);
        i_fifo_level = 9'd3;
        cyc();
        check("t4_resume", 32'(o_state), 2);

        // 5: rejected busy config write, then ARM|ABORT
        i_fifo_level = 9'd0;
        cfg(3'd1, 32'd5);
        check("t5_cfg_err", 32'(o_cfg_err), 1);
        cyc();
        check("t5_cfg_err_pulse", 32'(o_cfg_err), 0);
        i_hit_valid = 1'b1; i_hit_symbol = 5'd3; i_hit_perf = 32'h500;
        cfg(3'd0, 32'h3);
        i_hit_valid = 1'b0;
        check("t5_abort_wins", 32'(o_state), 0);
        check("t5_drop_hold", 32'(o_drop_count), 6);
        cfg(3'd0, 32'h5);
        hit(5'd5, 32'h501, 1'b0);
        hit(5'd7, 32'h502, 1'b1);
        check("t5_start_sym_kept", 32'(o_state), 2);
        check("t5_mark_count", 32'(o_mark_count), 1);
        cyc();

        // 6: asynchronous reset with a write in flight
        i_hit_valid = 1'b1; i_hit_symbol = 5'd4; i_hit_perf = 32'h600;
        @(posedge clk);
        #1 i_hit_valid = 1'b0;
        check("t6_inflight", 32'(o_mark_wr), 1);
        rst_n = 1'b0;
        #1;
        check("t6_mark_wr", 32'(o_mark_wr), 0);
        check("t6_state", 32'(o_state), 0);
        check("t6_mark_count", 32'(o_mark_count), 0);
        check("t6_symbol", 32'(o_mark_symbol), 0);
        check("t6_perf", o_mark_perf, 0);
        check("t6_done_irq_err", 32'({o_done, o_irq, o_cfg_err}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
